digilock_ctrl: RTL

Combination-lock controller for the DigiLock design. It consumes the single-cycle press pulses produced by the per-button debouncers and sequences code entry, comparison, code programming, failed-attempt lockout and automatic relock. It sits between the debouncer bank and the lock/indicator outputs, and it owns the stored combination.

---
 rtl/digilock_pkg.sv | 22 ++
 rtl/lock_timer.sv | 31 +++
 rtl/digilock_ctrl.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/digilock_pkg.sv
`default_nettype none
// ============================================================================
// Module  : digilock_pkg
// Brief   : Shared types and default sizes for the DigiLock controller.
// Revision: 1.0 - initial release
// ============================================================================
package digilock_pkg;

    localparam int DIGIT_W_DEF  = 2;
    localparam int CODE_LEN_DEF = 4;

    typedef logic [CODE_LEN_DEF*DIGIT_W_DEF-1:0] code_t;

    typedef enum logic [1:0] {
        LS_LOCKED   = 2'd0,
        LS_UNLOCKED = 2'd1,
        LS_PROGRAM  = 2'd2,
        LS_LOCKOUT  = 2'd3
    } lock_state_t;

endpackage
`default_nettype wire

// File: rtl/lock_timer.sv
`default_nettype none
// ============================================================================
// Module  : lock_timer
// Brief   : Loadable down-counter; expired flags the last counted cycle.
// Revision: 1.0 - initial release
// ============================================================================
module lock_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] value,
    output logic         expired
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            value <= '0;
        else if (load)
            value <= load_val;
        else if (value != '0)
            value <= value - 1'b1;
    end

    // A load of N makes expired high in the Nth cycle after the load edge.
    assign expired = (value == W'(1));

endmodule
`default_nettype wire

// File: rtl/digilock_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : digilock_ctrl
// Brief   : Combination-lock FSM: entry, compare, programming, lockout, relock.
// Revision: 1.0 - initial release
// ============================================================================
module digilock_ctrl #(
    parameter int CODE_LEN    = 4,
    parameter int NUM_KEYS    = 4,
    parameter int DIGIT_W     = 2,
    parameter int MAX_FAIL    = 3,
    parameter int LOCKOUT_CYC = 100_000_000,
    parameter int RELOCK_CYC  = 500_000_000,
    parameter logic [CODE_LEN*DIGIT_W-1:0] RESET_CODE = {2'd0, 2'd1, 2'd2, 2'd3}
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_KEYS-1:0]           digit_pulse,
    input  logic                          enter_pulse,
    input  logic                          clear_pulse,
    input  logic                          set_pulse,
    output logic                          unlocked,
    output logic                          prog_mode,
    output logic                          lockout,
    output logic [$clog2(CODE_LEN+2)-1:0] digit_cnt,
    output logic [$clog2(MAX_FAIL+1)-1:0] fail_cnt,
    output logic                          ok_pulse,
    output logic                          bad_pulse
);
    import digilock_pkg::*;

    localparam int DCW  = $clog2(CODE_LEN+2);
    localparam int FCW  = $clog2(MAX_FAIL+1);
    localparam int CW   = CODE_LEN*DIGIT_W;
    localparam int TMAX = (LOCKOUT_CYC > RELOCK_CYC) ? LOCKOUT_CYC : RELOCK_CYC;
    localparam int TW   = $clog2(TMAX+1);

    localparam logic [1:0] S_LOCKED   = LS_LOCKED;
    localparam logic [1:0] S_UNLOCKED = LS_UNLOCKED;
    localparam logic [1:0] S_PROGRAM  = LS_PROGRAM;
    localparam logic [1:0] S_LOCKOUT  = LS_LOCKOUT;

    logic [1:0]         r_state, w_state;
    logic [DCW-1:0]     r_digit_cnt, w_digit_cnt, w_dig_inc;
    logic               r_mismatch, w_mismatch;
    logic [FCW-1:0]     r_fail_cnt, w_fail_cnt, w_fail_inc;
    logic [CW-1:0]      r_code, w_code, r_buf, w_buf;
    logic               r_ok, w_ok, r_bad, w_bad;
    logic               w_one_hot;
    logic [DIGIT_W-1:0] w_key_val, w_slot;
    logic               w_clr, w_ent, w_set, w_dig;
    logic               w_tmr_load, w_tmr_exp;
    logic [TW-1:0]      w_tmr_val, w_tmr_value;
    logic               w_tmr_value_unused;

    // Strict one-event-per-cycle priority: clear > enter > set > digit.
    assign w_one_hot = (digit_pulse != '0) && ((digit_pulse & (digit_pulse - 1'b1)) == '0);
    assign w_clr = clear_pulse;
    assign w_ent = enter_pulse & ~clear_pulse;
    assign w_set = set_pulse & ~enter_pulse & ~clear_pulse;
    assign w_dig = w_one_hot & ~set_pulse & ~enter_pulse & ~clear_pulse;

    always_comb begin
        w_key_val = '0;
        for (int k = 0; k < NUM_KEYS; k++)
            if (digit_pulse[k]) w_key_val = DIGIT_W'(k);
        w_slot = '0;
        for (int i = 0; i < CODE_LEN; i++)
            if (r_digit_cnt == DCW'(i)) w_slot = r_code[(CODE_LEN-1-i)*DIGIT_W +: DIGIT_W];
    end

    assign w_dig_inc  = (r_digit_cnt == DCW'(CODE_LEN+1)) ? r_digit_cnt : r_digit_cnt + 1'b1;
    assign w_fail_inc = r_fail_cnt + 1'b1;

    always_comb begin
        w_state     = r_state;
        w_digit_cnt = r_digit_cnt;
        w_mismatch  = r_mismatch;
        w_fail_cnt  = r_fail_cnt;
        w_code      = r_code;
        w_buf       = r_buf;
        w_ok        = 1'b0;
        w_bad       = 1'b0;
        w_tmr_load  = 1'b0;
        w_tmr_val   = TW'(RELOCK_CYC);
        case (r_state)
            S_LOCKED: begin
                if (w_clr) begin
                    w_digit_cnt = '0;
                    w_mismatch  = 1'b0;
                end else if (w_ent) begin
                    w_digit_cnt = '0;
                    w_mismatch  = 1'b0;
                    if (r_digit_cnt == DCW'(CODE_LEN) && !r_mismatch) begin
                        w_ok       = 1'b1;
                        w_fail_cnt = '0;
                        w_state    = S_UNLOCKED;
                        w_tmr_load = 1'b1;
                    end else begin
                        w_bad      = 1'b1;
                        w_fail_cnt = w_fail_inc;
                        if (w_fail_inc == FCW'(MAX_FAIL)) begin
                            w_state    = S_LOCKOUT;
                            w_tmr_load = 1'b1;
                            w_tmr_val  = TW'(LOCKOUT_CYC);
                        end
                    end
                end else if (w_dig) begin
                    w_digit_cnt = w_dig_inc;
                    if (r_digit_cnt >= DCW'(CODE_LEN) || w_key_val != w_slot)
                        w_mismatch = 1'b1;
                end
            end
            S_LOCKOUT: begin
                if (w_tmr_exp) begin
                    w_state    = S_LOCKED;
                    w_fail_cnt = '0;
                end
            end
            S_UNLOCKED: begin
                if (w_ent) begin
                    w_state = S_LOCKED;
                end else if (w_set) begin
                    w_state     = S_PROGRAM;
                    w_digit_cnt = '0;
                    w_buf       = '0;
                    w_tmr_load  = 1'b1;
                end else if (w_tmr_exp) begin
                    w_state = S_LOCKED;
                end
            end
            default: begin // S_PROGRAM
                if (w_clr || w_ent) begin
                    w_state     = S_UNLOCKED;
                    w_digit_cnt = '0;
                    w_buf       = '0;
                    w_tmr_load  = 1'b1;
                    if (w_ent && r_digit_cnt == DCW'(CODE_LEN)) begin
                        w_code = r_buf;
                        w_ok   = 1'b1;
                    end else if (w_ent) begin
                        w_bad = 1'b1;
                    end
                end else if (w_dig) begin
                    w_digit_cnt = w_dig_inc;
                    w_tmr_load  = 1'b1;
                    if (r_digit_cnt < DCW'(CODE_LEN))
                        w_buf = (r_buf << DIGIT_W) | CW'(w_key_val);
                end else if (w_tmr_exp) begin
                    w_state     = S_LOCKED;
                    w_digit_cnt = '0;
                    w_buf       = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_LOCKED;
            r_digit_cnt <= '0;
            r_mismatch  <= 1'b0;
            r_fail_cnt  <= '0;
            r_code      <= RESET_CODE;
            r_buf       <= '0;
            r_ok        <= 1'b0;
            r_bad       <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_digit_cnt <= w_digit_cnt;
            r_mismatch  <= w_mismatch;
            r_fail_cnt  <= w_fail_cnt;
            r_code      <= w_code;
            r_buf       <= w_buf;
            r_ok        <= w_ok;
            r_bad       <= w_bad;
        end
    end

    // Lockout and inactivity share one counter; they are never active together.
    lock_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (w_tmr_load),
        .load_val (w_tmr_val),
        .value    (w_tmr_value),
        .expired  (w_tmr_exp)
    );
    assign w_tmr_value_unused = ^w_tmr_value;

    assign unlocked  = (r_state == S_UNLOCKED) || (r_state == S_PROGRAM);
    assign prog_mode = (r_state == S_PROGRAM);
    assign lockout   = (r_state == S_LOCKOUT);
    assign digit_cnt = r_digit_cnt;
    assign fail_cnt  = r_fail_cnt;
    assign ok_pulse  = r_ok;
    assign bad_pulse = r_bad;

endmodule
`default_nettype wire
